mipi_bridge_i2c_slave: RTL and testbench
========================================

MIPI_BRIDGE_I2C_SLAVE -- requirements
Module: mipi_bridge_i2c_slave

Interface
REQ-001 Parameter: I2C_ADDR, default 7'h0E, 7-bit target address (8-bit write byte 0x1C, read byte 0x1D).
REQ-002 Port: CLK_50  input  1  system clock, sole clock domain; all logic on its rising edge.
REQ-003 Port: RESET_N  input  1  reset; asynchronous, active-low.
REQ-004 Port: I2C_SCL  input  1  bus clock from initiator; never driven.
REQ-005 Port: I2C_SDA  inout  1  open-drain data; driven 1'b0 or released to 1'bz, never driven 1.
REQ-006 Port: REG_ADDR  output  16  register pointer presented to the local register file.
REQ-007 Port: REG_WDATA  output  16  write word.
REQ-008 Port: REG_WE  output  1  one-cycle write strobe.
REQ-009 Port: REG_RE  output  1  one-cycle read strobe.
REQ-010 Port: REG_RDATA  input  16  read word; valid 2 CLK_50 cycles after REG_RE.
REQ-011 Port: BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-012 SCL and SDA shall each pass a 2-FF synchronizer plus one history FF; all edge detection uses the synchronized values.
REQ-013 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both are honoured in every state, including mid-byte.
REQ-014 START, including a repeated START, shall clear the bit counter and enter ADDR; STOP shall release SDA and enter IDLE.
REQ-015 States: IDLE, ADDR, PTR_HI, PTR_LO, WDAT_HI, WDAT_LO, RDAT_HI, RDAT_LO, MACK, IGNORE; every received byte ends in a 9th-bit ACK slot.
REQ-016 Receive bits shall be sampled on SCL rising, MSB first; SDA output changes only on detected SCL falling.
REQ-017 ACK: drive SDA low from the SCL fall after bit 8 until the SCL fall after bit 9.
REQ-018 Address byte[7:1] != I2C_ADDR -> no ACK, state IGNORE, SDA released until the next START/STOP.
REQ-019 Write (R/W=0): ACK the address, then PTR_HI and PTR_LO; the pointer updates only after both pointer bytes are ACKed.
REQ-020 Then WDAT_HI and WDAT_LO. After the WDAT_LO ACK slot: REG_WE=1 for exactly one cycle with REG_ADDR=pointer and REG_WDATA={hi,lo}; pointer += 2; loop to WDAT_HI.
REQ-021 Pointer arithmetic is 16-bit modulo; 0xFFFE + 2 = 0x0000.
REQ-022 A STOP or START before the WDAT_LO ACK discards the partial word: no REG_WE.
REQ-023 Read (R/W=1): ACK the address; REG_RE pulses on the ACK-slot SCL fall; REG_RDATA is captured 2 cycles later into a 16-bit shift register.
REQ-024 Shift out RDAT_HI then RDAT_LO, MSB first, releasing SDA during each MACK slot.
REQ-025 Initiator ACK after RDAT_LO -> pointer += 2, new REG_RE, continue. Initiator NACK -> release SDA and go to IGNORE.
REQ-026 Initiator ACK after RDAT_HI -> continue to RDAT_LO; NACK after RDAT_HI -> IGNORE, pointer unchanged.
REQ-027 Timing assumption: SCL high and low phases are each >= 8 CLK_50 cycles; 400 kHz gives about 62.
REQ-028 The pointer persists across transactions; a read without a preceding pointer write uses the last pointer.

Reset
REQ-029 RESET_N low -> state IDLE, SDA released, REG_ADDR=0, REG_WDATA=0, REG_WE=0, REG_RE=0, BUSY=0, pointer=0, shift registers and counters cleared.
REQ-030 Reset asserted mid-transaction aborts immediately without a strobe. After release, the block waits for a fresh START.

Verification
REQ-031 Write 0x1C,0x00,0x02,0x00,0x01,STOP -> 5 ACKs; a single REG_WE with REG_ADDR=0x0002, REG_WDATA=0x0001.
REQ-032 Write 0x1C,0x00,0x00; repeated START; 0x1D; REG_RDATA=0x4401 -> bytes 0x44 then 0x01 on SDA; REG_RE once; pointer=0x0002 after the initiator ACK.
REQ-033 Address 0x1E or 0x3C -> SDA never driven low, no REG_WE/REG_RE, BUSY=1 until STOP, then 0.
REQ-034 Burst write at pointer 0xFFFE with 2 words (0x1234, 0x5678) -> REG_WE at 0xFFFE=0x1234, then 0x0000=0x5678.
REQ-035 STOP after WDAT_HI, and separately a repeated START mid WDAT_LO -> no REG_WE; pointer keeps the value from PTR_LO.
REQ-036 RESET_N pulsed low during an RDAT_HI bit driven 0 -> SDA=z within 1 cycle; all outputs at reset values; the next transaction completes normally.

Source files
------------

// File: rtl/mipi_bridge_i2c_slave.sv
// I2C target that maps 16-bit pointer/data words onto a local register file.
// Ports: CLK_50/RESET_N clock+async reset; I2C_SCL in, I2C_SDA open-drain;
//        REG_ADDR/REG_WDATA/REG_WE/REG_RE/REG_RDATA register file side; BUSY.
module mipi_bridge_i2c_slave #(
  parameter logic [6:0] I2C_ADDR = 7'h0E
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        I2C_SCL,
  inout  wire         I2C_SDA,
  output logic [15:0] REG_ADDR,
  output logic [15:0] REG_WDATA,
  output logic        REG_WE,
  output logic        REG_RE,
  input  logic [15:0] REG_RDATA,
  output logic        BUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_PTR_HI, S_PTR_LO, S_WDAT_HI,
    S_WDAT_LO, S_RDAT_HI, S_RDAT_LO, S_MACK, S_IGNORE
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_scl_s1, r_scl_s2, r_scl_h;
  logic        r_sda_s1, r_sda_s2, r_sda_h;
  logic [3:0]  r_cnt;
  logic [7:0]  r_sh;
  logic [7:0]  r_hi;
  logic [15:0] r_rsh;
  logic [15:0] r_ptr;
  logic [15:0] r_wdata;
  logic        r_we, r_re, r_re_req;
  logic        r_re_d1, r_re_d2;
  logic        r_oe, r_lo, r_mack;
  logic        w_rise, w_fall, w_start, w_stop, w_match;

  assign w_rise  = r_scl_s2 & ~r_scl_h;
  assign w_fall  = ~r_scl_s2 & r_scl_h;
  assign w_start = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop  = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_match = (r_sh[7:1] == I2C_ADDR);

  assign I2C_SDA   = r_oe ? 1'b0 : 1'bz;
  assign REG_ADDR  = r_ptr;
  assign REG_WDATA = r_wdata;
  assign REG_WE    = r_we;
  assign REG_RE    = r_re;
  assign BUSY      = (r_state != S_IDLE);

  // Bus lines reset to 1 so a released bus never looks like an edge.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_h} <= {I2C_SCL, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_h} <= {I2C_SDA, r_sda_s1, r_sda_s2};
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // r_cnt counts SCL rises in a byte: 8 = ACK slot opens, 9 = ACK slot ends.
  always_comb begin
    w_state_nx = r_state;
    if (w_start) begin
      w_state_nx = S_ADDR;
    end else if (w_stop) begin
      w_state_nx = S_IDLE;
    end else if (w_fall) begin
      unique case (r_state)
        S_ADDR: begin
          if (r_cnt == 4'd8 && !w_match) w_state_nx = S_IGNORE;
          else if (r_cnt == 4'd9)
            w_state_nx = r_sh[0] ? S_RDAT_HI : S_PTR_HI;
        end
        S_PTR_HI:  if (r_cnt == 4'd9) w_state_nx = S_PTR_LO;
        S_PTR_LO:  if (r_cnt == 4'd9) w_state_nx = S_WDAT_HI;
        S_WDAT_HI: if (r_cnt == 4'd9) w_state_nx = S_WDAT_LO;
        S_WDAT_LO: if (r_cnt == 4'd9) w_state_nx = S_WDAT_HI;
        S_RDAT_HI, S_RDAT_LO: if (r_cnt == 4'd8) w_state_nx = S_MACK;
        S_MACK: begin
          if (r_cnt == 4'd9) begin
            if (r_mack)    w_state_nx = S_IGNORE;
            else if (r_lo) w_state_nx = S_RDAT_HI;
            else           w_state_nx = S_RDAT_LO;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt    <= '0;
      r_sh     <= '0;
      r_hi     <= '0;
      r_rsh    <= '0;
      r_ptr    <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_re_req <= 1'b0;
      r_re_d1  <= 1'b0;
      r_re_d2  <= 1'b0;
      r_oe     <= 1'b0;
      r_lo     <= 1'b0;
      r_mack   <= 1'b0;
    end else begin
      r_we     <= 1'b0;
      r_re     <= r_re_req;
      r_re_req <= 1'b0;
      r_re_d1  <= r_re;
      r_re_d2  <= r_re_d1;
      // Register file answers two cycles after the strobe.
      if (r_re_d2) r_rsh <= REG_RDATA;
      // Post-increment lands the cycle after the strobe, so the strobe
      // still presents the old pointer.
      if (r_we) r_ptr <= r_ptr + 16'd2;
      if (w_start || w_stop) begin
        r_oe  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == S_IDLE || r_state == S_IGNORE) begin
        r_oe <= 1'b0;
      end else if (w_rise) begin
        r_cnt  <= r_cnt + 4'd1;
        r_mack <= r_sda_s2;
        if (r_cnt < 4'd8) r_sh <= {r_sh[6:0], r_sda_s2};
        // Initiator ACK after the low byte: fetch the next word early
        // so it is ready before the next SCL fall.
        if (r_state == S_MACK && !r_sda_s2 && r_lo) begin
          r_ptr    <= r_ptr + 16'd2;
          r_re_req <= 1'b1;
        end
      end else if (w_fall) begin
        unique case (r_state)
          S_ADDR: begin
            if (r_cnt == 4'd8) begin
              r_oe <= w_match;
              r_re <= w_match & r_sh[0];
            end else if (r_cnt == 4'd9) begin
              r_cnt <= '0;
              r_oe  <= r_sh[0] & ~r_rsh[15];
              if (r_sh[0]) r_rsh <= {r_rsh[14:0], 1'b0};
            end
          end
          S_PTR_HI, S_WDAT_HI: begin
            if (r_cnt == 4'd8) begin
              r_oe <= 1'b1;
              r_hi <= r_sh;
            end else if (r_cnt == 4'd9) begin
              r_oe  <= 1'b0;
              r_cnt <= '0;
            end
          end
          S_PTR_LO: begin
            if (r_cnt == 4'd8) begin
              r_oe <= 1'b1;
            end else if (r_cnt == 4'd9) begin
              r_oe  <= 1'b0;
              r_cnt <= '0;
              r_ptr <= {r_hi, r_sh};
            end
          end
          S_WDAT_LO: begin
            if (r_cnt == 4'd8) begin
              r_oe <= 1'b1;
            end else if (r_cnt == 4'd9) begin
              r_oe    <= 1'b0;
              r_cnt   <= '0;
              r_we    <= 1'b1;
              r_wdata <= {r_hi, r_sh};
            end
          end
          S_RDAT_HI, S_RDAT_LO: begin
            if (r_cnt == 4'd8) begin
              r_oe <= 1'b0;
              r_lo <= (r_state == S_RDAT_LO);
            end else begin
              r_oe  <= ~r_rsh[15];
              r_rsh <= {r_rsh[14:0], 1'b0};
            end
          end
          S_MACK: begin
            if (r_cnt == 4'd9) begin
              r_cnt <= '0;
              if (!r_mack) begin
                r_oe  <= ~r_rsh[15];
                r_rsh <= {r_rsh[14:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mipi_bridge_i2c_slave.sv
// Bench for mipi_bridge_i2c_slave: bus-level initiator, register file,
// strobe scoreboard and a word-level pointer/memory reference model.
module tb_mipi_bridge_i2c_slave;

  localparam int H = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        m_low;
  wire         sda;
  logic [15:0] reg_addr, reg_wdata, reg_rdata;
  logic        reg_we, reg_re, busy;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  mipi_bridge_i2c_slave #(.I2C_ADDR(7'h0E)) dut (
    .CLK_50   (clk),
    .RESET_N  (rst_n),
    .I2C_SCL  (scl),
    .I2C_SDA  (sda),
    .REG_ADDR (reg_addr),
    .REG_WDATA(reg_wdata),
    .REG_WE   (reg_we),
    .REG_RE   (reg_re),
    .REG_RDATA(reg_rdata),
    .BUSY     (busy)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          dut_low = 0;
  logic [15:0] regf [0:65535];
  logic [15:0] mdl  [0:65535];
  logic [15:0] rd_p1;
  logic [15:0] m_ptr;
  logic [15:0] wbuf [0:3];

  // Register file: data appears two cycles after the read strobe.
  always @(posedge clk) begin
    if (reg_re) rd_p1 <= regf[reg_addr];
    reg_rdata <= rd_p1;
  end

  // Strobe monitor: every WE/RE must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (sda === 1'b0 && !m_low) dut_low++;
    if (reg_we || reg_re) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected we=%0b re=%0b addr=%h data=%h",
                 reg_we, reg_re, reg_addr, reg_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.we !== reg_we || e.a !== reg_addr ||
            (reg_we && e.d !== reg_wdata)) begin
          errors++;
          $display("FAIL strobe: got we=%0b addr=%h data=%h want we=%0b addr=%h data=%h",
                   reg_we, reg_addr, reg_wdata, e.we, e.a, e.d);
        end
      end
      if (reg_we) regf[reg_addr] = reg_wdata;
    end
  end

  task automatic chk(input string n, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; hold(H);
    scl = 1'b1;   hold(H);
    m_low = 1'b1; hold(H);
    scl = 1'b0;   hold(H);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; hold(H);
    scl = 1'b1;   hold(H);
    m_low = 1'b0; hold(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      m_low = ~b[i]; hold(H);
      scl = 1'b1;    hold(H);
      scl = 1'b0;    hold(2);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack);
    logic a;
    send_bits(b, 8);
    m_low = 1'b0; hold(H);
    scl = 1'b1;   hold(H / 2);
    a = sda;      hold(H / 2);
    scl = 1'b0;   hold(2);
    chk("ack", 16'(a), 16'(exp_ack));
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack);
    logic [7:0] b;
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      hold(H);
      scl = 1'b1; hold(H / 2);
      b[i] = sda; hold(H / 2);
      scl = 1'b0; hold(2);
    end
    m_low = ~nack; hold(H);
    scl = 1'b1;    hold(H);
    scl = 1'b0;    hold(2);
    m_low = 1'b0;
    chk("rbyte", 16'(b), 16'(exp));
  endtask

  task automatic tx_ptr(input logic [15:0] p, input bit stop);
    i2c_start();
    write_byte(8'h1C, 1'b0);
    write_byte(p[15:8], 1'b0);
    write_byte(p[7:0], 1'b0);
    m_ptr = p;
    if (stop) begin
      i2c_stop();
      chk("ptr", reg_addr, m_ptr);
    end
  endtask

  task automatic tx_write(input logic [15:0] p, input int n);
    tx_ptr(p, 1'b0);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(ev_t'{1'b1, m_ptr, wbuf[k]});
      mdl[m_ptr] = wbuf[k];
      write_byte(wbuf[k][15:8], 1'b0);
      write_byte(wbuf[k][7:0], 1'b0);
      m_ptr = m_ptr + 16'd2;
    end
    i2c_stop();
    chk("ptr", reg_addr, m_ptr);
  endtask

  // Reads n words; the last word ends with NACK on its high or low byte.
  task automatic tx_read(input int n, input bit nack_hi);
    bit last;
    i2c_start();
    exp_q.push_back(ev_t'{1'b0, m_ptr, 16'h0});
    write_byte(8'h1D, 1'b0);
    for (int k = 0; k < n; k++) begin
      last = (k == n - 1);
      read_byte(mdl[m_ptr][15:8], last && nack_hi);
      if (last && nack_hi) break;
      if (!last) exp_q.push_back(ev_t'{1'b0, m_ptr + 16'd2, 16'h0});
      read_byte(mdl[m_ptr][7:0], last);
      if (!last) m_ptr = m_ptr + 16'd2;
    end
    i2c_stop();
    chk("ptr", reg_addr, m_ptr);
  endtask

  task automatic tx_bad(input logic [7:0] a);
    int d0;
    d0 = dut_low;
    i2c_start();
    write_byte(a, 1'b1);
    chk("busy_ign", 16'(busy), 16'd1);
    write_byte(8'h00, 1'b1);
    chk("busy_ign2", 16'(busy), 16'd1);
    i2c_stop();
    chk("busy_stop", 16'(busy), 16'd0);
    chk("no_drive", 16'(dut_low - d0), 16'd0);
  endtask

  task automatic chk_reset_outs(input string n);
    chk({n, "_sda"},   16'(sda), 16'd1);
    chk({n, "_addr"},  reg_addr, 16'h0000);
    chk({n, "_wdata"}, reg_wdata, 16'h0000);
    chk({n, "_we"},    16'(reg_we), 16'd0);
    chk({n, "_re"},    16'(reg_re), 16'd0);
    chk({n, "_busy"},  16'(busy), 16'd0);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  ba;
    rst_n = 1'b0;
    scl   = 1'b1;
    m_low = 1'b0;
    m_ptr = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      regf[i] = v;
      mdl[i]  = v;
    end
    hold(5);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    hold(5);

    wbuf[0] = 16'h0001;
    tx_write(16'h0002, 1);

    regf[0] = 16'h4401;
    mdl[0]  = 16'h4401;
    tx_ptr(16'h0000, 1'b0);
    tx_read(2, 1'b1);

    tx_bad(8'h1E);
    tx_bad(8'h3C);

    wbuf[0] = 16'h1234;
    wbuf[1] = 16'h5678;
    tx_write(16'hFFFE, 2);

    tx_ptr(16'h0100, 1'b0);
    write_byte(8'hAB, 1'b0);
    i2c_stop();
    chk("ptr_abort_stop", reg_addr, m_ptr);

    tx_ptr(16'h0200, 1'b0);
    write_byte(8'hCD, 1'b0);
    send_bits(8'hEF, 4);
    tx_read(1, 1'b0);

    regf[16'h0020] = 16'h0F0F;
    mdl[16'h0020]  = 16'h0F0F;
    tx_ptr(16'h0020, 1'b1);
    i2c_start();
    exp_q.push_back(ev_t'{1'b0, m_ptr, 16'h0});
    write_byte(8'h1D, 1'b0);
    hold(4);
    chk("rd_drive0", 16'(sda), 16'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outs("midreset");
    hold(3);
    rst_n = 1'b1;
    m_ptr = 16'h0000;
    hold(3);
    i2c_stop();
    wbuf[0] = 16'h0A0B;
    tx_write(16'h0040, 1);
    m_ptr = 16'h0040;
    tx_ptr(16'h0040, 1'b1);
    tx_read(1, 1'b0);

    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          for (int k = 0; k < 3; k++) wbuf[k] = 16'($urandom);
          if ($urandom_range(0, 2) == 0) v = 16'hFFFC;
          else v = 16'($urandom);
          tx_write(v, int'($urandom_range(1, 3)));
        end
        1: tx_read(int'($urandom_range(1, 3)), 1'b0);
        2: tx_read(int'($urandom_range(1, 2)), 1'b1);
        3: begin
          ba = 8'($urandom);
          if (ba[7:1] == 7'h0E) ba = ba ^ 8'h80;
          tx_bad(ba);
        end
        default: tx_ptr(16'($urandom), 1'b1);
      endcase
    end

    hold(20);
    chk("pending", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
